// File: rtl/pc_fetch_if.sv
// Instruction-memory request channel between the fetch stage and memory.
// The fetch side drives request/address; memory answers with ack/data.
interface pc_fetch_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemRdata
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemRdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Fetch stage: PC sequencing, instruction-memory requests and a single
// output register to decode, with redirect and stale-response dropping.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        BranchMux,
    input  logic [31:0] BranchTarget,
    input  logic        Stall,
    pc_fetch_if.master  imem,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    output logic [31:0] PC
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    logic        consume;
    logic        room;
    logic        req;
    logic [31:0] pc_inc;
    logic [31:0] tgt;

    assign consume = valid_q && !Stall;
    assign room    = !valid_q || !Stall;
    assign pc_inc  = pc_q + 32'd4;
    assign tgt     = BranchTarget & ~32'd3;

    // A full, stalled output register suppresses the request at once.
    assign req = ((state_q == FETCH) && room) || (state_q == DROP);

    assign imem.IMemReq  = req;
    assign imem.IMemAddr = addr_q;
    assign Instr         = instr_q;
    assign InstrPC       = ipc_q;
    assign InstrValid    = valid_q;
    assign PC            = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;

        if (consume) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (BranchMux) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    // An unanswered request must be drained before refetching.
                    if (req && !imem.IMemAck) begin
                        state_d = DROP;
                    end else begin
                        addr_d = tgt;
                    end
                end else if (!room) begin
                    state_d = HOLD;
                end else if (imem.IMemAck) begin
                    instr_d = imem.IMemRdata;
                    ipc_d   = addr_q;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                end
            end
            HOLD: begin
                if (BranchMux) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    addr_d  = tgt;
                    state_d = FETCH;
                end else if (consume) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (BranchMux) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (imem.IMemAck) begin
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: streaming, stall/hold, redirects, wrap
// and asynchronous reset during an outstanding dropped request.
module tb_pc_fetch;

    localparam logic [31:0] KEY = 32'hC0DE_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [31:0] target;
    logic        stall;
    logic        ack;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic [31:0] pc;

    int chk;
    int err;

    pc_fetch_if bus ();

    // Memory image: each word is its address XOR a fixed key.
    assign bus.IMemAck   = ack;
    assign bus.IMemRdata = bus.IMemAddr ^ KEY;

    pc_fetch dut (
        .Clk         (clk),
        .RstN        (rst_n),
        .BranchMux   (branch),
        .BranchTarget(target),
        .Stall       (stall),
        .imem        (bus),
        .Instr       (instr),
        .InstrPC     (ipc),
        .InstrValid  (valid),
        .PC          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch = 1'b0; target = 32'd0; stall = 1'b0; ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk++; if (bus.IMemReq !== 1'b0) begin err++; $display("FAIL rst_req got %h exp 0", bus.IMemReq); end
        chk++; if (bus.IMemAddr !== 32'h0) begin err++; $display("FAIL rst_addr got %h exp 00000000", bus.IMemAddr); end
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL rst_valid got %h exp 0", valid); end
        chk++; if (instr !== NOP) begin err++; $display("FAIL rst_instr got %h exp %h", instr, NOP); end
        chk++; if (ipc !== 32'h0) begin err++; $display("FAIL rst_ipc got %h exp 00000000", ipc); end
        chk++; if (pc !== 32'h0) begin err++; $display("FAIL rst_pc got %h exp 00000000", pc); end
        rst_n = 1'b1;
        #1;
        chk++; if (bus.IMemReq !== 1'b0) begin err++; $display("FAIL boot_req got %h exp 0", bus.IMemReq); end
    endtask

    task automatic test_stream();
        step();
        chk++; if (bus.IMemReq !== 1'b1) begin err++; $display("FAIL first_req got %h exp 1", bus.IMemReq); end
        chk++; if (bus.IMemAddr !== 32'h0) begin err++; $display("FAIL first_addr got %h exp 00000000", bus.IMemAddr); end
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL first_valid got %h exp 0", valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            chk++; if (ipc !== 32'(4 * k)) begin err++; $display("FAIL stream_ipc got %h exp %h", ipc, 32'(4 * k)); end
            chk++; if (instr !== (32'(4 * k) ^ KEY)) begin err++; $display("FAIL stream_instr got %h exp %h", instr, 32'(4 * k) ^ KEY); end
            chk++; if (valid !== 1'b1) begin err++; $display("FAIL stream_valid got %h exp 1", valid); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        chk++; if (bus.IMemReq !== 1'b0) begin err++; $display("FAIL stall_req got %h exp 0", bus.IMemReq); end
        for (int k = 0; k < 3; k++) begin
            step();
            chk++; if (ipc !== 32'h14) begin err++; $display("FAIL hold_ipc got %h exp 00000014", ipc); end
            chk++; if (instr !== (32'h14 ^ KEY)) begin err++; $display("FAIL hold_instr got %h exp %h", instr, 32'h14 ^ KEY); end
            chk++; if (bus.IMemReq !== 1'b0) begin err++; $display("FAIL hold_req got %h exp 0", bus.IMemReq); end
        end
        stall = 1'b0;
        step();
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL resume_valid got %h exp 0", valid); end
        chk++; if (bus.IMemReq !== 1'b1) begin err++; $display("FAIL resume_req got %h exp 1", bus.IMemReq); end
        chk++; if (bus.IMemAddr !== 32'h18) begin err++; $display("FAIL resume_addr got %h exp 00000018", bus.IMemAddr); end
        step();
        chk++; if (ipc !== 32'h18 || valid !== 1'b1) begin err++; $display("FAIL resume_ipc got %h/%h exp 00000018/1", ipc, valid); end
        step();
        chk++; if (ipc !== 32'h1C) begin err++; $display("FAIL resume_next got %h exp 0000001c", ipc); end
    endtask

    task automatic test_redirect_drop();
        ack = 1'b0; branch = 1'b1; target = 32'h0000_0103;
        step();
        branch = 1'b0;
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL drop_valid got %h exp 0", valid); end
        chk++; if (instr !== NOP) begin err++; $display("FAIL drop_instr got %h exp %h", instr, NOP); end
        chk++; if (pc !== 32'h100) begin err++; $display("FAIL drop_pc got %h exp 00000100", pc); end
        chk++; if (bus.IMemAddr !== 32'h20 || bus.IMemReq !== 1'b1) begin err++; $display("FAIL drop_addr got %h/%h exp 00000020/1", bus.IMemAddr, bus.IMemReq); end
        for (int k = 0; k < 2; k++) begin
            step();
            chk++; if (bus.IMemAddr !== 32'h20 || valid !== 1'b0) begin err++; $display("FAIL drop_wait got %h/%h exp 00000020/0", bus.IMemAddr, valid); end
        end
        ack = 1'b1;
        step();
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL drop_discard got %h exp 0", valid); end
        chk++; if (bus.IMemAddr !== 32'h100) begin err++; $display("FAIL drop_refetch got %h exp 00000100", bus.IMemAddr); end
        step();
        chk++; if (ipc !== 32'h100 || valid !== 1'b1) begin err++; $display("FAIL drop_ipc got %h/%h exp 00000100/1", ipc, valid); end
        chk++; if (instr !== (32'h100 ^ KEY)) begin err++; $display("FAIL drop_word got %h exp %h", instr, 32'h100 ^ KEY); end
        step();
        chk++; if (ipc !== 32'h104) begin err++; $display("FAIL drop_next got %h exp 00000104", ipc); end
    endtask

    task automatic test_same_cycle();
        branch = 1'b1; target = 32'h0000_0200; stall = 1'b1; ack = 1'b1;
        step();
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL same_valid got %h exp 0", valid); end
        chk++; if (bus.IMemAddr !== 32'h200) begin err++; $display("FAIL same_addr got %h exp 00000200", bus.IMemAddr); end
        target = 32'h0000_0303;
        #1;
        chk++; if (bus.IMemReq !== 1'b1) begin err++; $display("FAIL same_req got %h exp 1", bus.IMemReq); end
        step();
        chk++; if (valid !== 1'b0) begin err++; $display("FAIL same_ack_valid got %h exp 0", valid); end
        chk++; if (instr !== NOP) begin err++; $display("FAIL same_ack_instr got %h exp %h", instr, NOP); end
        chk++; if (bus.IMemAddr !== 32'h300 || pc !== 32'h300) begin err++; $display("FAIL same_ack_addr got %h/%h exp 00000300", bus.IMemAddr, pc); end
        branch = 1'b0; stall = 1'b0;
        step();
        chk++; if (ipc !== 32'h300 || valid !== 1'b1) begin err++; $display("FAIL same_ipc got %h/%h exp 00000300/1", ipc, valid); end
    endtask

    task automatic test_wrap();
        branch = 1'b1; target = 32'hFFFF_FFFF;
        step();
        branch = 1'b0;
        chk++; if (pc !== 32'hFFFF_FFFC || bus.IMemAddr !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_tgt got %h/%h exp fffffffc", pc, bus.IMemAddr); end
        step();
        chk++; if (ipc !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_ipc0 got %h exp fffffffc", ipc); end
        chk++; if (instr !== 32'h3F21_FFFC) begin err++; $display("FAIL wrap_instr0 got %h exp 3f21fffc", instr); end
        chk++; if (pc !== 32'h0) begin err++; $display("FAIL wrap_pc got %h exp 00000000", pc); end
        step();
        chk++; if (ipc !== 32'h0 || instr !== KEY) begin err++; $display("FAIL wrap_ipc1 got %h/%h exp 00000000/%h", ipc, instr, KEY); end
    endtask

    task automatic test_reset_drop();
        ack = 1'b0; branch = 1'b1; target = 32'h0000_0400;
        step();
        branch = 1'b0;
        chk++; if (bus.IMemReq !== 1'b1 || valid !== 1'b0) begin err++; $display("FAIL rd_drop got %h/%h exp 1/0", bus.IMemReq, valid); end
        #2;
        rst_n = 1'b0;
        #1;
        chk++; if (bus.IMemReq !== 1'b0) begin err++; $display("FAIL rd_req got %h exp 0", bus.IMemReq); end
        chk++; if (bus.IMemAddr !== 32'h0 || pc !== 32'h0) begin err++; $display("FAIL rd_addr got %h/%h exp 00000000", bus.IMemAddr, pc); end
        chk++; if (instr !== NOP || ipc !== 32'h0) begin err++; $display("FAIL rd_instr got %h/%h exp %h/00000000", instr, ipc, NOP); end
        @(negedge clk);
        ack = 1'b1;
        rst_n = 1'b1;
        step();
        chk++; if (valid !== 1'b0 || bus.IMemAddr !== 32'h0) begin err++; $display("FAIL rd_boot got %h/%h exp 0/00000000", valid, bus.IMemAddr); end
        step();
        chk++; if (ipc !== 32'h0 || instr !== KEY || valid !== 1'b1) begin err++; $display("FAIL rd_first got %h/%h exp 00000000/%h", ipc, instr, KEY); end
    endtask

    initial begin
        chk = 0;
        err = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_same_cycle();
        test_wrap();
        test_reset_drop();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
